timer_rdy_gen: RTL and testbench

//  Programmable countdown timer. Produces the RDY strobe that paces the

---
 rtl/timer_rdy_gen.sv | 81 ++++++++
 tb/tb_timer_rdy_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_rdy_gen.sv
// Programmable countdown timer producing a one-cycle RDY strobe every P*PRESCALE clocks (one-shot or periodic).
// Latency: START at edge E0 -> RDY high in the cycle after edge E0 + P*PRESCALE.
// Backpressure: none; STOP overrides START, and START overrides a pending tick.
module timer_rdy_gen #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic             STOP,
    input  logic [WIDTH-1:0] PERIOD,
    input  logic             MODE,
    output logic             RDY,
    output logic             BUSY,
    output logic [WIDTH-1:0] COUNT
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] per_q;
    logic             mode_q;
    logic             rdy;
    logic             tick;
    logic [WIDTH-1:0] start_per;

    assign tick      = (state == S_RUN) && (presc == PS_MAX);
    // A zero period would never expire; treat it as the shortest legal period.
    assign start_per = (PERIOD == '0) ? WIDTH'(1) : PERIOD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            presc  <= '0;
            count  <= '0;
            per_q  <= '0;
            mode_q <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (STOP) begin
                state <= S_IDLE;
                count <= '0;
                presc <= '0;
            end else if (START) begin
                per_q  <= start_per;
                mode_q <= MODE;
                count  <= start_per;
                presc  <= '0;
                state  <= S_RUN;
            end else if (tick) begin
                presc <= '0;
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else begin
                    rdy <= 1'b1;
                    if (mode_q) begin
                        count <= per_q;
                    end else begin
                        count <= '0;
                        state <= S_IDLE;
                    end
                end
            end else if (state == S_RUN) begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign RDY   = rdy;
    assign BUSY  = (state == S_RUN);
    assign COUNT = count;

endmodule

// File: tb/tb_timer_rdy_gen.sv
// Randomized + directed bench for timer_rdy_gen; an arithmetic model predicts each cycle's outputs into a queue.
module tb_timer_rdy_gen;

    localparam int WIDTH = 8;
    localparam int PS    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic [WIDTH-1:0] PERIOD = '0;
    logic             MODE = 1'b0;
    logic             RDY;
    logic             BUSY;
    logic [WIDTH-1:0] COUNT;

    timer_rdy_gen #(.WIDTH(WIDTH), .PRESCALE(PS)) dut (
        .clk(clk), .reset(reset), .START(START), .STOP(STOP),
        .PERIOD(PERIOD), .MODE(MODE), .RDY(RDY), .BUSY(BUSY), .COUNT(COUNT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             rdy;
        logic             busy;
        logic [WIDTH-1:0] count;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_seen = 0;

    // Reference: time since the last START, split into whole ticks, decides everything.
    int   ecnt = 0;
    int   m_arm = 0;
    int   m_p = 1;
    bit   m_mode = 1'b0;
    bit   m_run = 1'b0;
    int   el, t, ec;
    bit   er;

    always @(posedge clk) begin
        exp_t e;
        ecnt++;
        er = 1'b0;
        ec = 0;
        if (!reset || STOP) begin
            m_run = 1'b0;
        end else if (START) begin
            m_run  = 1'b1;
            m_arm  = ecnt;
            m_p    = (PERIOD == '0) ? 1 : int'(PERIOD);
            m_mode = MODE;
        end
        if (m_run) begin
            el = ecnt - m_arm;
            t  = el / PS;
            if (m_mode) begin
                er = (el > 0) && (el % PS == 0) && (t % m_p == 0);
                ec = m_p - (t % m_p);
            end else if (t >= m_p) begin
                er    = (el == m_p * PS);
                m_run = 1'b0;
                ec    = 0;
            end else begin
                ec = m_p - t;
            end
        end
        e.rdy   = er;
        e.busy  = m_run;
        e.count = WIDTH'(ec);
        q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (RDY) rdy_seen++;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({RDY, BUSY, COUNT} !== e) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got rdy=%b busy=%b count=%0d, want rdy=%b busy=%b count=%0d",
                         $time, RDY, BUSY, COUNT, e.rdy, e.busy, e.count);
            end
        end
    end

    task automatic check_now(input string name, input logic [WIDTH+1:0] want);
        n_cmp++;
        if ({RDY, BUSY, COUNT} !== want) begin
            n_bad++;
            $display("FAIL %s: got {rdy,busy,count}=%h, want %h", name, {RDY, BUSY, COUNT}, want);
        end
    endtask

    task automatic check_rdy(input string name, input int base, input int want);
        n_cmp++;
        if (rdy_seen - base !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d RDY strobes, want %0d", name, rdy_seen - base, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse(input int per, input bit md);
        START  = 1'b1;
        PERIOD = WIDTH'(per);
        MODE   = md;
        @(negedge clk);
        START  = 1'b0;
        PERIOD = WIDTH'($urandom_range(0, 255));
        MODE   = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check_now("reset_async", '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int base;

    initial begin
        #2;
        check_now("reset_state", '0);
        idle(2);
        reset = 1'b1;
        idle(2);

        // one-shot P=3: single strobe after 12 cycles
        base = rdy_seen;
        start_pulse(3, 1'b0);
        idle(20);
        check_rdy("oneshot_p3", base, 1);

        // periodic P=2, stopped at E26
        base = rdy_seen;
        start_pulse(2, 1'b1);
        idle(25);
        STOP = 1'b1;
        @(negedge clk);
        STOP = 1'b0;
        check_now("stop_clears", '0);
        idle(10);
        check_rdy("periodic_p2", base, 3);

        // restart at E10 pushes the strobe out to E30
        base = rdy_seen;
        start_pulse(5, 1'b0);
        idle(9);
        start_pulse(5, 1'b0);
        idle(18);
        check_rdy("restart_before", base, 0);
        idle(4);
        check_rdy("restart_after", base, 1);

        // START and STOP together: STOP wins
        base = rdy_seen;
        start_pulse(3, 1'b1);
        idle(3);
        START = 1'b1;
        STOP  = 1'b1;
        @(negedge clk);
        START = 1'b0;
        STOP  = 1'b0;
        check_now("start_stop_same", '0);
        idle(20);
        check_rdy("start_stop_no_rdy", base, 0);

        // PERIOD=0 behaves as 1
        base = rdy_seen;
        start_pulse(0, 1'b0);
        idle(8);
        check_rdy("period_zero", base, 1);

        // reset mid-run with COUNT=2
        base = rdy_seen;
        start_pulse(3, 1'b0);
        idle(5);
        check_now("pre_reset_count2", {1'b0, 1'b1, WIDTH'(2)});
        pulse_reset();
        idle(20);
        check_rdy("reset_no_rdy", base, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            START  = ($urandom_range(0, 39) == 0);
            STOP   = ($urandom_range(0, 149) == 0);
            PERIOD = WIDTH'($urandom_range(0, 7));
            MODE   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 799) == 0) begin
                START = 1'b0;
                STOP  = 1'b0;
                pulse_reset();
            end else begin
                @(negedge clk);
            end
        end
        START = 1'b0;
        STOP  = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
